// File: rtl/srg_mult_pkg.sv
// Shared definitions for the MULT/MULTU sequencer: state encoding and timing constants.
package srg_mult_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int MUL_STEPS = DEF_WIDTH;
   localparam int LATENCY   = DEF_WIDTH + 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_NEG_A  = 3'd1,
      ST_NEG_B  = 3'd2,
      ST_MUL    = 3'd3,
      ST_NEG_LO = 3'd4,
      ST_NEG_HI = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

endpackage

// File: rtl/srg_mult_seq.sv
// Radix-2 shift-add MULT/MULTU sequencer. Signed operands are reduced to magnitudes,
// multiplied unsigned, and the 64-bit result is negated at the end when the signs differ.
// All additions go through one external adder reached via the add_* ports.
module srg_mult_seq
   import srg_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout
);

   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic             carry_q, carry_d;
   logic             neg_q, neg_d;
   logic             sgn_q, sgn_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Adder operand selection: depends only on state and registers, never on inputs.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state_q)
         ST_NEG_A: begin
            add_a   = ~mcand_q;
            add_cin = 1'b1;
         end
         ST_NEG_B: begin
            add_a   = ~lo_q;
            add_cin = 1'b1;
         end
         ST_MUL: begin
            add_a = hi_q;
            add_b = lo_q[0] ? mcand_q : '0;
         end
         ST_NEG_LO: begin
            add_a   = ~lo_q;
            add_cin = 1'b1;
         end
         ST_NEG_HI: begin
            add_a   = ~hi_q;
            add_cin = carry_q;
         end
         default: ;
      endcase
   end

   // Next-state and datapath update; the low-half negate carry feeds the high-half negate.
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      step_d  = step_q;
      carry_d = carry_q;
      neg_d   = neg_q;
      sgn_d   = sgn_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_NEG_A;
               mcand_d = op_a;
               lo_d    = op_b;
               hi_d    = '0;
               sgn_d   = is_signed;
               neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
               carry_d = 1'b0;
               step_d  = '0;
            end
         end
         ST_NEG_A: begin
            if (sgn_q & mcand_q[WIDTH-1]) mcand_d = add_sum;
            state_d = ST_NEG_B;
         end
         ST_NEG_B: begin
            if (sgn_q & lo_q[WIDTH-1]) lo_d = add_sum;
            state_d = ST_MUL;
         end
         ST_MUL: begin
            {hi_d, lo_d} = {add_cout, add_sum, lo_q[WIDTH-1:1]};
            if (step_q == LAST_STEP) begin
               step_d  = '0;
               state_d = ST_NEG_LO;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         ST_NEG_LO: begin
            if (neg_q) begin
               lo_d    = add_sum;
               carry_d = add_cout;
            end
            state_d = ST_NEG_HI;
         end
         ST_NEG_HI: begin
            if (neg_q) hi_d = add_sum;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers; reset aborts any operation and clears all results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         step_q  <= '0;
         carry_q <= 1'b0;
         neg_q   <= 1'b0;
         sgn_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         step_q  <= step_d;
         carry_q <= carry_d;
         neg_q   <= neg_d;
         sgn_q   <= sgn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
